// File: rtl/hog_pkg.sv
// Shared HOG pipeline constants: cell/block geometry and block cell indices.
// Imported by the histogram, block assembly and normalization stages.
package hog_pkg;
    localparam int BIN_WIDTH   = 14;
    localparam int BINS        = 9;
    localparam int CELL_WIDTH  = BIN_WIDTH * (BINS + 1);
    localparam int BLOCK_WIDTH = 4 * CELL_WIDTH;

    // Cell position inside an assembled 2x2 block
    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BL = 2;
    localparam int BR = 3;

    typedef logic [CELL_WIDTH-1:0] cell_t;
endpackage

// File: rtl/hog_line_buffer.sv
// One row of cell histograms; read returns the pre-write contents of the same address.
// Write is registered and read is combinational, so a same-cycle read sees old data.
module hog_line_buffer
    import hog_pkg::*;
#(
    parameter int DEPTH = 80,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  cell_t         wdata_i,
    output cell_t         rdata_o
);
    cell_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];
endmodule

// File: rtl/hog_block_assembler.sv
// Builds 2x2 HOG blocks from a raster cell stream using one buffered cell row,
// with a single registered output stage towards the normalization stage.
module hog_block_assembler
    import hog_pkg::*;
#(
    parameter int CELL_COLS = 80,
    parameter int CELL_ROWS = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cell_valid,
    output logic                   cell_ready,
    input  logic [CELL_WIDTH-1:0]  cell_hist,
    output logic                   block_valid,
    input  logic                   block_ready,
    output logic [BLOCK_WIDTH-1:0] block_histograms,
    output logic                   block_last
);
    localparam int CW = (CELL_COLS > 1) ? $clog2(CELL_COLS) : 1;
    localparam int RW = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(CELL_COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(CELL_ROWS - 1);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    cell_t                  left_bot_q, left_bot_d;
    cell_t                  left_top_q, left_top_d;
    logic                   vld_q, vld_d;
    logic                   last_q, last_d;
    logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
    cell_t                  lb_rd;
    logic                   accept, emit;

    assign cell_ready = !vld_q || block_ready;
    assign accept     = cell_valid && cell_ready;
    assign emit       = accept && (row_q != '0) && (col_q != '0);

    hog_line_buffer #(.DEPTH(CELL_COLS), .AW(CW)) u_linebuf (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (cell_hist),
        .rdata_o (lb_rd)
    );

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        left_bot_d = left_bot_q;
        left_top_d = left_top_q;
        vld_d      = vld_q;
        last_d     = last_q;
        blk_d      = blk_q;
        if (accept) begin
            left_bot_d = cell_hist;
            left_top_d = lb_rd;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        // A fresh block overrides a draining one; otherwise the stage empties on handshake
        if (emit) begin
            vld_d  = 1'b1;
            last_d = (row_q == ROW_MAX) && (col_q == COL_MAX);
            blk_d[BR*CELL_WIDTH +: CELL_WIDTH] = cell_hist;
            blk_d[BL*CELL_WIDTH +: CELL_WIDTH] = left_bot_q;
            blk_d[TR*CELL_WIDTH +: CELL_WIDTH] = lb_rd;
            blk_d[TL*CELL_WIDTH +: CELL_WIDTH] = left_top_q;
        end else if (block_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            left_bot_q <= '0;
            left_top_q <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            blk_q      <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            left_bot_q <= left_bot_d;
            left_top_q <= left_top_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            blk_q      <= blk_d;
        end
    end

    assign block_valid      = vld_q;
    assign block_last       = last_q;
    assign block_histograms = blk_q;
endmodule

// File: tb/tb_hog_block_assembler.sv
// Bench for hog_block_assembler: a 4x3 instance for directed cases and an 80x60
// instance for randomized multi-frame traffic, both checked against a frame-array model.
module tb_hog_block_assembler;
    import hog_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cell_valid = 1'b0;
    logic block_ready = 1'b0;
    logic [CELL_WIDTH-1:0] cell_hist = '0;

    logic cr_s, bv_s, bl_s, cr_b, bv_b, bl_b;
    logic [BLOCK_WIDTH-1:0] bh_s, bh_b;

    bit big = 1'b0;
    int ncols = 4;
    int nrows = 3;

    logic cr_o, bv_o, bl_o;
    logic [BLOCK_WIDTH-1:0] bh_o;
    assign cr_o = big ? cr_b : cr_s;
    assign bv_o = big ? bv_b : bv_s;
    assign bl_o = big ? bl_b : bl_s;
    assign bh_o = big ? bh_b : bh_s;

    always #5 clk = ~clk;

    hog_block_assembler #(.CELL_COLS(4), .CELL_ROWS(3)) dut_s (
        .clk(clk), .rst(rst), .cell_valid(cell_valid), .cell_ready(cr_s),
        .cell_hist(cell_hist), .block_valid(bv_s), .block_ready(block_ready),
        .block_histograms(bh_s), .block_last(bl_s)
    );

    hog_block_assembler #(.CELL_COLS(80), .CELL_ROWS(60)) dut_b (
        .clk(clk), .rst(rst), .cell_valid(cell_valid), .cell_ready(cr_b),
        .cell_hist(cell_hist), .block_valid(bv_b), .block_ready(block_ready),
        .block_histograms(bh_b), .block_last(bl_b)
    );

    // Reference model: the whole frame as a 2D array; a block is four neighbouring cells
    logic [CELL_WIDTH-1:0]  frame_m [60][80];
    logic [BLOCK_WIDTH-1:0] exp_q[$];
    bit                     exp_last_q[$];
    logic [BLOCK_WIDTH-1:0] seen_d[$];
    bit                     seen_l[$];
    int mr = 0, mc = 0;
    int ncomp = 0, nfail = 0;
    int nblk = 0, nlast = 0;

    function automatic logic [CELL_WIDTH-1:0] mk(input int k);
        logic [CELL_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b <= BINS; b++) r[b*BIN_WIDTH +: BIN_WIDTH] = BIN_WIDTH'(k);
        return r;
    endfunction

    function automatic logic [BLOCK_WIDTH-1:0] blk4(input int br, input int bl, input int tr, input int tl);
        return {mk(br), mk(bl), mk(tr), mk(tl)};
    endfunction

    function automatic logic [CELL_WIDTH-1:0] rnd_cell();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[CELL_WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [BLOCK_WIDTH-1:0] obs, input logic [BLOCK_WIDTH-1:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven at the negedge; handshakes are judged 1ns later, before the next posedge
    task automatic step(input bit v, input logic [CELL_WIDTH-1:0] h, input bit br);
        bit acc;
        cell_valid  = v;
        cell_hist   = h;
        block_ready = br;
        #1;
        chk("block_valid", bv_o, exp_q.size() != 0);
        chk("cell_ready", cr_o, (exp_q.size() == 0) || br);
        acc = v && ((exp_q.size() == 0) || br);
        if (bv_o && br && exp_q.size() != 0) begin
            chk("block_data", bh_o, exp_q[0]);
            chk("block_last", bl_o, exp_last_q[0]);
            seen_d.push_back(bh_o);
            seen_l.push_back(bl_o);
            nblk++;
            if (bl_o) nlast++;
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
        end
        if (acc) begin
            frame_m[mr][mc] = h;
            if (mr > 0 && mc > 0) begin
                exp_q.push_back({h, frame_m[mr][mc-1], frame_m[mr-1][mc], frame_m[mr-1][mc-1]});
                exp_last_q.push_back(mr == nrows - 1 && mc == ncols - 1);
            end
            mc++;
            if (mc == ncols) begin
                mc = 0;
                mr++;
                if (mr == nrows) mr = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        cell_valid  = 1'b0;
        block_ready = 1'b0;
        #1;
        chk("rst_block_valid", bv_o, 0);
        chk("rst_block_last", bl_o, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        seen_d.delete();
        seen_l.delete();
        mr = 0;
        mc = 0;
    endtask

    task automatic small_frame();
        for (int k = 0; k < 12; k++) step(1'b1, mk(k), 1'b1);
    endtask

    initial begin
        logic [BLOCK_WIDTH-1:0] held;
        logic held_l;
        logic [CELL_WIDTH-1:0] cur;
        bit v, br, acc;
        int acc_cnt, cyc;

        @(negedge clk);
        do_reset();
        chk("rst_data", bh_o, '0);
        chk("rst_cell_ready", cr_o, 1);

        // Single 4x3 frame, counting cells
        small_frame();
        repeat (2) step(1'b0, '0, 1'b1);
        chk("small_count", seen_d.size(), 6);
        chk("small_first", seen_d[0], blk4(5, 4, 1, 0));
        chk("small_first_last", seen_l[0], 0);
        chk("small_final", seen_d[5], blk4(11, 10, 7, 6));
        chk("small_final_last", seen_l[5], 1);

        // Two frames back-to-back
        do_reset();
        small_frame();
        small_frame();
        repeat (2) step(1'b0, '0, 1'b1);
        chk("b2b_count", seen_d.size(), 12);
        for (int i = 0; i < 6; i++) chk("b2b_repeat", seen_d[i+6], seen_d[i]);
        chk("b2b_f2_first", seen_d[6], blk4(5, 4, 1, 0));
        chk("b2b_f2_last", seen_l[11], 1);

        // Back-pressure: downstream stalls for 5 cycles with a block pending
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, mk(k), 1'b1);
        held   = bh_o;
        held_l = bl_o;
        chk("stall_block", held, blk4(5, 4, 1, 0));
        repeat (5) begin
            step(1'b1, mk(6), 1'b0);
            chk("stall_hold_data", bh_o, held);
            chk("stall_hold_last", bl_o, held_l);
        end
        for (int k = 6; k < 12; k++) step(1'b1, mk(k), 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        chk("stall_count", seen_d.size(), 6);

        // Reset mid-frame with a block pending, then a clean frame
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, rnd_cell(), 1'b1);
        chk("pre_rst_valid", bv_o, 1);
        do_reset();
        small_frame();
        repeat (2) step(1'b0, '0, 1'b1);
        chk("rst_restart_count", seen_d.size(), 6);
        chk("rst_restart_first", seen_d[0], blk4(5, 4, 1, 0));
        chk("rst_restart_final", seen_d[5], blk4(11, 10, 7, 6));

        // Random traffic over three full 80x60 frames
        big   = 1'b1;
        ncols = 80;
        nrows = 60;
        do_reset();
        nblk    = 0;
        nlast   = 0;
        acc_cnt = 0;
        cyc     = 0;
        cur     = rnd_cell();
        while (acc_cnt < 3 * 4800 && cyc < 90000) begin
            v   = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            acc = v && ((exp_q.size() == 0) || br);
            step(v, cur, br);
            if (acc) begin
                acc_cnt++;
                cur = rnd_cell();
            end
            cyc++;
        end
        repeat (3) step(1'b0, cur, 1'b1);
        chk("rand_cells_accepted", acc_cnt, 3 * 4800);
        chk("rand_block_count", nblk, 3 * 4661);
        chk("rand_last_count", nlast, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
